// File: rtl/mc_controller.sv
// Multi-cycle ARM-style instruction controller with a handshaked multiply/FPU unit.
// Outputs depend only on state and Instr; flag registers feed DECODE's condition check.
module mc_controller #(
    parameter int EX_TIMEOUT = 16,
    parameter int HAS_FPU    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic [3:0]  FPUFlags,
    input  logic        ExDone,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        ExStart,
    output logic        ExTimeout,
    output logic        UndefInstr,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ExControl
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_EXWAIT, S_EXWB
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic       ex_start;
        logic       ex_timeout;
        logic       undef_instr;
        logic [1:0] result_src;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [1:0] alu_control;
        logic [1:0] ex_control;
    } ctrl_t;

    localparam logic [7:0] TO_LAST = 8'(EX_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] alu_flags_q, alu_flags_d;
    logic [3:0] fpu_flags_q, fpu_flags_d;
    logic [3:0] fpu_lat_q, fpu_lat_d;
    logic       timeout_q, timeout_d;
    ctrl_t      ctrl;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic       rd_is_pc, is_mul, is_cmp, cond_ex;
    logic [1:0] alu_op, ex_op;
    logic       unused_instr_bits;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign rd_is_pc = (Instr[15:12] == 4'b1111);
    assign is_mul   = (op == 2'b00) && (funct[5:1] == 5'b00000) && (Instr[7:4] == 4'b1001);
    assign is_cmp   = (funct[4:1] == 4'b1010);
    assign ex_op    = is_mul ? 2'b11 : funct[2:1];
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cy;
            4'h3:    return !cy;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cy && !z;
            4'h9:    return !cy || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign cond_ex = cond_check(cond, (op == 2'b11) ? fpu_flags_q : alu_flags_q);

    always_comb begin
        case (funct[4:1])
            4'b0100: alu_op = 2'b00;
            4'b0010: alu_op = 2'b01;
            4'b0000: alu_op = 2'b10;
            4'b1100: alu_op = 2'b11;
            default: alu_op = 2'b00;
        endcase
    end

    always_comb begin
        ctrl        = '0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_flags_d = alu_flags_q;
        fpu_flags_d = fpu_flags_q;
        fpu_lat_d   = fpu_lat_q;
        timeout_d   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                ctrl.ex_timeout = timeout_q;
                state_d         = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                cnt_d           = '0;
                state_d         = S_FETCH;
                if (op == 2'b11 && HAS_FPU == 0) begin
                    ctrl.undef_instr = 1'b1;
                end else if (cond_ex) begin
                    if (op == 2'b01) begin
                        state_d = S_MEMADR;
                    end else if (op == 2'b10) begin
                        state_d = S_BRANCH;
                    end else if (is_mul || op == 2'b11) begin
                        ctrl.ex_start   = 1'b1;
                        ctrl.ex_control = ex_op;
                        state_d         = S_EXWAIT;
                    end else begin
                        state_d = funct[5] ? S_EXECI : S_EXECR;
                    end
                end
            end
            S_MEMADR: begin
                ctrl.alu_src_b = 2'b01;
                state_d        = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.adr_src = 1'b1;
                state_d      = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = 2'b01;
                ctrl.pc_write   = rd_is_pc;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXECR: begin
                ctrl.alu_control = alu_op;
                state_d          = S_ALUWB;
            end
            S_EXECI: begin
                ctrl.alu_src_b   = 2'b01;
                ctrl.alu_control = alu_op;
                state_d          = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = !is_cmp;
                ctrl.pc_write  = !is_cmp && rd_is_pc;
                if (funct[0]) begin
                    alu_flags_d = ALUFlags;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_b  = 2'b01;
                ctrl.imm_src    = 2'b10;
                ctrl.result_src = 2'b10;
                ctrl.pc_write   = 1'b1;
                state_d         = S_FETCH;
            end
            S_EXWAIT: begin
                ctrl.ex_control = ex_op;
                cnt_d           = cnt_q + 8'd1;
                // ExDone has priority over a timeout landing on the same cycle
                if (ExDone) begin
                    fpu_lat_d = FPUFlags;
                    state_d   = S_EXWB;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = 2'b11;
                if (funct[0]) begin
                    fpu_flags_d = fpu_lat_q;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Every strobe, FETCH ones included, is held low while reset is asserted
    assign {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ExStart, ExTimeout,
            UndefInstr, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, ExControl}
           = reset ? ctrl : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            cnt_q       <= '0;
            alu_flags_q <= '0;
            fpu_flags_q <= '0;
            fpu_lat_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_flags_q <= alu_flags_d;
            fpu_flags_q <= fpu_flags_d;
            fpu_lat_q   <= fpu_lat_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction expected output traces built from the
// instruction-level rules, compared every cycle, plus literal pins on pulse counts.
module tb_mc_controller;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags, FPUFlags;
    logic        ExDone;

    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ExStart, ExTimeout, UndefInstr;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, ExControl;
    logic        n_pcw, n_adr, n_mw, n_irw, n_rw, n_asa, n_exs, n_ext, n_und;
    logic [1:0]  n_rs, n_asb, n_imm, n_rsrc, n_aluc, n_exc;

    always #5 clk = ~clk;

    mc_controller #(.EX_TIMEOUT(TO), .HAS_FPU(1)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .FPUFlags(FPUFlags),
        .ExDone(ExDone), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ExStart(ExStart),
        .ExTimeout(ExTimeout), .UndefInstr(UndefInstr), .ResultSrc(ResultSrc),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .ExControl(ExControl)
    );

    mc_controller #(.EX_TIMEOUT(16), .HAS_FPU(0)) dut_nofpu (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .FPUFlags(FPUFlags),
        .ExDone(ExDone), .PCWrite(n_pcw), .AdrSrc(n_adr), .MemWrite(n_mw),
        .IRWrite(n_irw), .RegWrite(n_rw), .ALUSrcA(n_asa), .ExStart(n_exs),
        .ExTimeout(n_ext), .UndefInstr(n_und), .ResultSrc(n_rs),
        .ALUSrcB(n_asb), .ImmSrc(n_imm), .RegSrc(n_rsrc), .ALUControl(n_aluc),
        .ExControl(n_exc)
    );

    logic [20:0] dut_v, nf_v;
    assign dut_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ExStart, ExTimeout,
                    UndefInstr, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, ExControl};
    assign nf_v  = {n_pcw, n_adr, n_mw, n_irw, n_rw, n_asa, n_exs, n_ext,
                    n_und, n_rs, n_asb, n_imm, n_rsrc, n_aluc, n_exc};

    int checks = 0, failures = 0;
    logic [20:0] exp_cur, nf_exp;
    bit exp_valid = 0, nf_valid = 0;
    int cyc = 0;
    int obs_rw, obs_mw, obs_exs, obs_ext, obs_pcw;

    // Architectural model state
    logic [3:0] alu_m, fpu_m;
    bit pend_to;

    function automatic logic [20:0] ov(input logic pcw, adr, mw, irw, rw, asa, exs, ext, und,
                                       input logic [1:0] rs, asb, imm, aluc, exc);
        return {pcw, adr, mw, irw, rw, asa, exs, ext, und, rs, asb, imm, 2'b00, aluc, exc};
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;           4'h1: return !z;
            4'h2: return cy;          4'h3: return !cy;
            4'h4: return n;           4'h5: return !n;
            4'h6: return v;           4'h7: return !v;
            4'h8: return cy & !z;     4'h9: return !cy | z;
            4'hA: return n == v;      4'hB: return n != v;
            4'hC: return !z & (n == v); 4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_sel(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] f, input logic [3:0] rd,
                                       input logic [3:0] mop);
        return {c, op, f, 4'h0, rd, 4'h0, mop, 4'h0};
    endfunction

    task automatic pin(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic clr_obs();
        obs_rw = 0; obs_mw = 0; obs_exs = 0; obs_ext = 0; obs_pcw = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        ExDone = 1'b0;
        nf_valid = 0;
        for (int i = 0; i < n; i++) begin
            exp_cur = '0;
            exp_valid = 1;
            $display("cyc=%0d reset", cyc);
            step();
        end
        reset = 1'b1;
        alu_m = 4'h0;
        fpu_m = 4'h0;
        pend_to = 0;
    endtask

    // Builds the expected trace of one instruction, drives it cycle by cycle,
    // then commits architectural effects unless a reset aborted it.
    task automatic run_instr(input string name, input logic [31:0] ins, input logic [3:0] af,
                             input logic [3:0] ff, input int done_at, input bit stray,
                             input int abort_at, input bit nf, output int ncyc);
        logic [20:0] so[$];
        bit sd[$];
        logic [20:0] nf_tab[3];
        logic [3:0] c, rd;
        logic [1:0] op, exc;
        logic [5:0] f;
        bit ok, mul, exu, upd_a, upd_f, to_hit, aborted, wr;
        int n;
        c = ins[31:28]; op = ins[27:26]; f = ins[25:20]; rd = ins[15:12];
        upd_a = 0; upd_f = 0; to_hit = 0; aborted = 0;
        ok  = cond_ok(c, (op == 2'b11) ? fpu_m : alu_m);
        mul = (op == 2'b00) && (f[5:1] == 5'd0) && (ins[7:4] == 4'b1001);
        exu = ok && (mul || op == 2'b11);
        exc = mul ? 2'b11 : f[2:1];

        so.push_back(ov(1, 0, 0, 1, 0, 1, 0, pend_to, 0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
        sd.push_back(stray);
        so.push_back(ov(0, 0, 0, 0, 0, 1, exu, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00,
                        exu ? exc : 2'b00));
        sd.push_back(stray);
        if (exu) begin
            for (int k = 0; ; k++) begin
                if (done_at > 0 && k == done_at - 1) begin
                    so.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, exc));
                    sd.push_back(1);
                    so.push_back(ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
                    sd.push_back(stray);
                    upd_f = f[0];
                    break;
                end
                so.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, exc));
                sd.push_back(0);
                if (k == TO - 1) begin
                    to_hit = 1;
                    break;
                end
            end
        end else if (ok && op == 2'b01) begin
            so.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
            sd.push_back(stray);
            if (f[0]) begin
                so.push_back(ov(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
                so.push_back(ov(rd == 4'hF, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
                sd.push_back(stray);
                sd.push_back(stray);
            end else begin
                so.push_back(ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
                sd.push_back(stray);
            end
        end else if (ok && op == 2'b10) begin
            so.push_back(ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00));
            sd.push_back(stray);
        end else if (ok && op == 2'b00) begin
            wr = (f[4:1] != 4'b1010);
            so.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, f[5] ? 2'b01 : 2'b00, 2'b00,
                            alu_sel(f[4:1]), 2'b00));
            so.push_back(ov(wr && rd == 4'hF, 0, 0, 0, wr, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00,
                            2'b00, 2'b00));
            sd.push_back(stray);
            sd.push_back(stray);
            upd_a = f[0];
        end
        pend_to = 0;

        nf_tab[0] = ov(1, 0, 0, 1, 0, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        nf_tab[1] = ov(0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        nf_tab[2] = nf_tab[0];

        Instr = ins;
        n = 0;
        for (int i = 0; i < so.size(); i++) begin
            if (i == abort_at) begin
                aborted = 1;
                break;
            end
            ALUFlags  = af;
            ExDone    = sd[i];
            FPUFlags  = sd[i] ? ff : ~ff;
            exp_cur   = so[i];
            exp_valid = 1;
            nf_valid  = nf && (i < 3);
            if (nf && i < 3) nf_exp = nf_tab[i];
            $display("cyc=%0d %s step=%0d exp=%h", cyc, name, i, so[i]);
            step();
            n++;
        end
        ExDone = 1'b0;
        nf_valid = 0;
        ncyc = n;
        if (aborted) begin
            do_reset(2);
        end else begin
            if (upd_a) alu_m = af;
            if (upd_f) fpu_m = ff;
            pend_to = to_hit;
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (exp_valid) begin
                checks++;
                if (dut_v !== exp_cur) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got=%h expected=%h", cyc, dut_v, exp_cur);
                end
                obs_rw  += int'(RegWrite);
                obs_mw  += int'(MemWrite);
                obs_exs += int'(ExStart);
                obs_ext += int'(ExTimeout);
                obs_pcw += int'(PCWrite);
            end
            if (nf_valid) begin
                checks++;
                if (nf_v !== nf_exp) begin
                    failures++;
                    $display("FAIL nofpu_outputs cyc=%0d got=%h expected=%h", cyc, nf_v, nf_exp);
                end
            end
            cyc++;
        end
    endtask

    task automatic main_flow();
        int nc;
        reset = 1'b0; Instr = '0; ALUFlags = '0; FPUFlags = '0; ExDone = 1'b0;
        alu_m = '0; fpu_m = '0; pend_to = 0;
        step();
        do_reset(2);

        // FPU op with no ExDone: times out after TO EXWAIT cycles
        clr_obs();
        run_instr("fpu_timeout", mk(4'hE, 2'b11, 6'b000101, 4'd2, 4'h0), 4'h0, 4'hF, 0, 0, -1, 1, nc);
        pin("fpu_timeout_cycles", nc, 6);
        pin("fpu_timeout_exstart", obs_exs, 1);
        pin("fpu_timeout_regwrite", obs_rw, 0);
        clr_obs();
        run_instr("fpu_eq_nottaken", mk(4'h0, 2'b11, 6'b000001, 4'd2, 4'h0), 4'h0, 4'hF, 1, 0, -1, 0, nc);
        pin("timeout_pulse", obs_ext, 1);
        pin("fpu_flags_unchanged_cycles", nc, 2);

        clr_obs();
        run_instr("adds", mk(4'hE, 2'b00, 6'b101001, 4'd1, 4'h0), 4'b0100, 4'h0, 0, 1, -1, 0, nc);
        pin("adds_cycles", nc, 4);
        pin("adds_regwrite", obs_rw, 1);
        clr_obs();
        run_instr("beq", mk(4'h0, 2'b10, 6'b100000, 4'd0, 4'h0), 4'h0, 4'h0, 0, 0, -1, 0, nc);
        pin("beq_cycles", nc, 3);
        pin("beq_pcwrite", obs_pcw, 2);
        clr_obs();
        run_instr("bne", mk(4'h1, 2'b10, 6'b100000, 4'd0, 4'h0), 4'h0, 4'h0, 0, 0, -1, 0, nc);
        pin("bne_cycles", nc, 2);
        pin("bne_pcwrite", obs_pcw, 1);

        clr_obs();
        run_instr("ldr", mk(4'hE, 2'b01, 6'b011001, 4'd3, 4'h0), 4'h0, 4'h0, 0, 0, -1, 0, nc);
        pin("ldr_cycles", nc, 5);
        pin("ldr_regwrite", obs_rw, 1);
        clr_obs();
        run_instr("str", mk(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0), 4'h0, 4'h0, 0, 0, -1, 0, nc);
        pin("str_cycles", nc, 4);
        pin("str_memwrite", obs_mw, 1);

        clr_obs();
        run_instr("muls", mk(4'hE, 2'b00, 6'b000001, 4'd4, 4'h9), 4'h0, 4'b1000, 3, 1, -1, 0, nc);
        pin("mul_cycles", nc, 6);
        pin("mul_exstart", obs_exs, 1);
        pin("mul_regwrite", obs_rw, 1);
        run_instr("fpu_mi", mk(4'h4, 2'b11, 6'b000011, 4'd5, 4'h0), 4'h0, 4'b0010, 1, 0, -1, 0, nc);
        pin("fpu_mi_cycles", nc, 4);
        clr_obs();
        run_instr("fpu_done_at_timeout", mk(4'hE, 2'b11, 6'b000010, 4'd6, 4'h0), 4'h0, 4'h0, TO, 0, -1, 0, nc);
        pin("done_wins_cycles", nc, 7);
        pin("done_wins_regwrite", obs_rw, 1);

        clr_obs();
        run_instr("add_never", mk(4'hF, 2'b00, 6'b101000, 4'd1, 4'h0), 4'h0, 4'h0, 0, 0, -1, 0, nc);
        pin("never_regwrite", obs_rw, 0);
        run_instr("sub", mk(4'hE, 2'b00, 6'b000100, 4'd5, 4'h0), 4'h3, 4'h0, 0, 0, -1, 0, nc);
        run_instr("and", mk(4'hE, 2'b00, 6'b000000, 4'd6, 4'h0), 4'h3, 4'h0, 0, 0, -1, 0, nc);
        run_instr("orr", mk(4'hE, 2'b00, 6'b111000, 4'd7, 4'h0), 4'h3, 4'h0, 0, 0, -1, 0, nc);
        clr_obs();
        run_instr("cmps", mk(4'hE, 2'b00, 6'b110101, 4'd0, 4'h0), 4'b1000, 4'h0, 0, 0, -1, 0, nc);
        pin("cmp_regwrite", obs_rw, 0);
        run_instr("bmi", mk(4'h4, 2'b10, 6'b100000, 4'd0, 4'h0), 4'h0, 4'h0, 0, 0, -1, 0, nc);
        pin("bmi_cycles", nc, 3);
        run_instr("bpl", mk(4'h5, 2'b10, 6'b100000, 4'd0, 4'h0), 4'h0, 4'h0, 0, 0, -1, 0, nc);
        clr_obs();
        run_instr("add_pc", mk(4'hE, 2'b00, 6'b101000, 4'hF, 4'h0), 4'h0, 4'h0, 0, 0, -1, 0, nc);
        pin("add_pc_pcwrite", obs_pcw, 2);
        clr_obs();
        run_instr("ldr_pc", mk(4'hE, 2'b01, 6'b011001, 4'hF, 4'h0), 4'h0, 4'h0, 0, 0, -1, 0, nc);
        pin("ldr_pc_pcwrite", obs_pcw, 2);

        // Resets landing mid-MEMWR and mid-EXWAIT
        clr_obs();
        run_instr("str_abort", mk(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0), 4'h0, 4'h0, 0, 0, 3, 0, nc);
        pin("str_abort_memwrite", obs_mw, 0);
        run_instr("adds_z", mk(4'hE, 2'b00, 6'b101001, 4'd1, 4'h0), 4'b0100, 4'h0, 0, 0, -1, 0, nc);
        clr_obs();
        run_instr("mul_abort", mk(4'hE, 2'b00, 6'b000001, 4'd4, 4'h9), 4'h0, 4'b0100, 3, 0, 3, 0, nc);
        pin("mul_abort_regwrite", obs_rw, 0);
        run_instr("beq_after_reset", mk(4'h0, 2'b10, 6'b100000, 4'd0, 4'h0), 4'h0, 4'h0, 0, 0, -1, 0, nc);
        pin("alu_flags_cleared", nc, 2);
        run_instr("fpu_eq_after_reset", mk(4'h0, 2'b11, 6'b000001, 4'd2, 4'h0), 4'h0, 4'h0, 1, 0, -1, 0, nc);
        pin("fpu_flags_cleared", nc, 2);
        exp_valid = 0;
    endtask

    initial begin
        fork
            compare_loop();
            main_flow();
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter EX_TIMEOUT, default 16: maximum EXWAIT cycles before abort; legal range 2..255.
REQ-002 Parameter HAS_FPU, default 1: 1 = Op 11 decoded as FPU op; 0 = Op 11 treated as undefined (UndefInstr pulse, no side effects).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-low: reset==0 at a rising edge resets all state.
REQ-005 Instr  input  [31:0] from IR: [31:28] Cond, [27:26] Op, [25:20] Funct, [15:12] Rd, [7:4] MulOp.
REQ-006 ALUFlags  input  4  NZCV from ALU, same cycle.
REQ-007 FPUFlags  input  4  NZCV from FPU/multiplier, valid with ExDone.
REQ-008 ExDone  input  1  one-cycle pulse from multi-cycle unit: result ready.
REQ-009 Outputs, all 1 bit unless given: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ExStart, ExTimeout, UndefInstr, ResultSrc[1:0], ALUSrcB[1:0], ImmSrc[1:0], RegSrc[1:0], ALUControl[1:0], ExControl[1:0].

Function
REQ-010 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, EXWAIT, EXWB; one state per cycle, except EXWAIT.
REQ-011 FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10; next DECODE.
REQ-012 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; CondEx evaluated from Cond against stored ALU flag register (Op!=11) or stored FPU flag register (Op==11), ARM condition table 0000..1110, 1111 = never.
REQ-013 DECODE with CondEx=0: next FETCH, no register, memory, flag or PC-branch side effect.
REQ-014 DECODE with CondEx=1: Op 01 -> MEMADR; Op 10 -> BRANCH; Op 00 with Funct[5:1]=00000 and MulOp=1001 -> EXWAIT (multiply, ExControl=11); Op 00 otherwise -> EXECI if Funct[5] else EXECR; Op 11 and HAS_FPU -> EXWAIT (ExControl=Funct[2:1]).
REQ-015 ExStart SHALL pulse exactly one cycle, on the DECODE->EXWAIT transition edge cycle (asserted in DECODE).
REQ-016 MEMADR: ALUSrcB=01, ALUControl=00; Funct[0]=1 -> MEMRD, else MEMWR.
REQ-017 MEMRD: AdrSrc=1 -> MEMWB; MEMWB: RegWrite=1, ResultSrc=01 -> FETCH; MEMWR: AdrSrc=1, MemWrite=1 -> FETCH.
REQ-018 EXECR/EXECI: ALUSrcB=00/01, ALUControl from Funct[4:1] (0100 ADD=00, 0010 SUB=01, 0000 AND=10, 1100 ORR=11) -> ALUWB.
REQ-019 ALUWB: RegWrite=1 unless Funct[4:1]=1010 (CMP); if Funct[0]=1, ALUFlags captured into ALU flag register at this edge; -> FETCH.
REQ-020 BRANCH: ALUSrcB=01, ImmSrc=10, ResultSrc=10 selects ALU, PCWrite=1 -> FETCH.
REQ-021 EXWAIT: 8-bit counter cleared on entry, increments each cycle; ExDone -> EXWB; counter reaching EX_TIMEOUT with no ExDone -> FETCH with ExTimeout=1 for one cycle, no writeback, no flag update.
REQ-022 ExDone and timeout in the same cycle: ExDone wins.
REQ-023 EXWB: RegWrite=1, ResultSrc=11; if Funct[0]=1, FPUFlags captured (latched from ExDone cycle) into FPU flag register; -> FETCH.
REQ-024 ExDone outside EXWAIT SHALL be ignored.
REQ-025 Rd=1111 write in ALUWB/MEMWB SHALL also assert PCWrite (PC load).
REQ-026 Unlisted outputs in any state = 0; all outputs are functions of state and Instr only (Moore plus decode).

Reset
REQ-027 reset==0: state=FETCH, both flag registers=0000, EXWAIT counter=0; all outputs except the FETCH strobes are 0 during reset; FETCH strobes are gated to 0 while reset==0.
REQ-028 reset mid-EXWAIT or mid-MEMWR: next state FETCH, no pending write or flag update performed afterwards.

Verification
REQ-029 ADDS R1,R2,#5 (Op00,Funct=101001), ALUFlags=0100 -> FETCH,DECODE,EXECI,ALUWB; RegWrite in ALUWB; ALU flag reg=0100.
REQ-030 BEQ after REQ-029 -> BRANCH with PCWrite=1; BNE -> DECODE->FETCH, no BRANCH.
REQ-031 LDR (Op01,Funct[0]=1) -> 5 cycles, MEMWB RegWrite=1, ResultSrc=01; STR -> 4 cycles, MemWrite=1 only in MEMWR.
REQ-032 MUL, ExDone after 3 EXWAIT cycles -> ExStart single pulse, EXWB RegWrite=1, ResultSrc=11.
REQ-033 FPU op, no ExDone, EX_TIMEOUT=4 -> 4 EXWAIT cycles, ExTimeout pulse, FETCH, no RegWrite, FPU flag reg unchanged.
REQ-034 HAS_FPU=0, Op11 -> UndefInstr pulse in DECODE, next FETCH; reset==0 held in EXWAIT -> FETCH, flags 0000.
